// File: rtl/past_history_arbiter_if.sv
// Bus bundle for the past-history arbiter: the sampling input, the
// per-requester request/distance/grant lines and the registered response.
// Parameters must match the ones given to past_history_arbiter.
interface past_history_arbiter_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int NREQ  = 3
);
  localparam int DW = $clog2(DEPTH + 1);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic                 sample_en;
  logic [WIDTH-1:0]     sample_data;
  logic [NREQ-1:0]      req;
  logic [NREQ*DW-1:0]   req_dist;
  logic [NREQ-1:0]      gnt;
  logic                 rsp_valid;
  logic [IW-1:0]        rsp_id;
  logic [WIDTH-1:0]     rsp_data;
  logic                 rsp_err;

  // Requesters and the sampled-expression source.
  modport master (
    output sample_en, sample_data, req, req_dist,
    input  gnt, rsp_valid, rsp_id, rsp_data, rsp_err
  );

  // The history buffer / arbiter itself.
  modport slave (
    input  sample_en, sample_data, req, req_dist,
    output gnt, rsp_valid, rsp_id, rsp_data, rsp_err
  );
endinterface

// File: rtl/past_history_arbiter.sv
// Shared history ring for a sampled expression. Records the last DEPTH
// enabled samples and serves "value k samples ago" lookups to NREQ
// requesters, one per cycle, in round-robin order. Responses are
// registered one cycle after the grant and use the pre-edge history.
module past_history_arbiter #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int NREQ  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  past_history_arbiter_if.slave bus
);
  localparam int DW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [DW-1:0]    fill_cnt;
  logic [IW-1:0]    rr_last;

  logic [NREQ-1:0]  gnt_vec;
  logic             gnt_any;
  logic [IW-1:0]    gnt_idx;
  logic [DW-1:0]    sel_dist;
  logic [PW-1:0]    rd_idx;
  logic             lookup_err;

  logic             rsp_valid_q;
  logic [IW-1:0]    rsp_id_q;
  logic [WIDTH-1:0] rsp_data_q;
  logic             rsp_err_q;

  // Round-robin search starting one past the last granted requester.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    gnt_vec = '0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    if (!rst) begin
      for (int off = 1; off <= NREQ; off++) begin
        // NOTE: blocking assignments are required here: later loop
        // iterations must see gnt_any already set by earlier ones.
        if (!gnt_any && bus.req[(int'(rr_last) + off) % NREQ]) begin
          gnt_any = 1'b1;
          gnt_idx = IW'((int'(rr_last) + off) % NREQ);
        end
      end
      if (gnt_any) gnt_vec[gnt_idx] = 1'b1;
    end
  end

  // Distance of the granted requester and the ring slot it addresses.
  // k == DEPTH wraps to wr_ptr itself, i.e. the oldest slot.
  always_comb begin
    sel_dist   = bus.req_dist[gnt_idx*DW +: DW];
    rd_idx     = wr_ptr - sel_dist[PW-1:0];
    lookup_err = (sel_dist == '0) || (sel_dist > fill_cnt);
  end

  // History storage: written on every enabled sample, never reset.
  // NOTE: the ring has no reset; fill_cnt=0 after reset makes every slot
  // unreadable, so clearing the array would only cost logic.
  always_ff @(posedge clk) begin
    if (bus.sample_en && !rst) mem[wr_ptr] <= bus.sample_data;
  end

  // Control state, arbiter pointer and registered response.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      fill_cnt    <= '0;
      rr_last     <= IW'(NREQ - 1);
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      if (bus.sample_en) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (fill_cnt != DW'(DEPTH)) fill_cnt <= fill_cnt + 1'b1;
      end
      rsp_valid_q <= gnt_any;
      if (gnt_any) begin
        rr_last    <= gnt_idx;
        rsp_id_q   <= gnt_idx;
        rsp_err_q  <= lookup_err;
        rsp_data_q <= lookup_err ? '0 : mem[rd_idx];
      end
    end
  end

  assign bus.gnt       = gnt_vec;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_past_history_arbiter.sv
// Self-checking bench for past_history_arbiter (WIDTH=8, DEPTH=4, NREQ=3).
// Table of per-cycle vectors with expected grant and expected response;
// responses go through a scoreboard queue and are compared when valid.
module tb_past_history_arbiter;
  logic clk = 1'b0;
  logic rst;

  past_history_arbiter_if #(.WIDTH(8), .DEPTH(4), .NREQ(3)) bus ();

  past_history_arbiter #(.WIDTH(8), .DEPTH(4), .NREQ(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       r;
    logic       se;
    logic [7:0] sd;
    logic [2:0] rq;
    logic [2:0] d0, d1, d2;
    logic [2:0] egnt;
    logic [7:0] edata;
    logic       eerr;
  } vec_t;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
    logic       err;
  } rsp_t;

  vec_t vecs[$];
  rsp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [1:0] oh_idx(input logic [2:0] oh);
    logic [1:0] r = 2'd0;
    for (int i = 0; i < 3; i++) if (oh[i]) r = 2'(i);
    return r;
  endfunction

  function automatic void add(input logic r, input logic se, input logic [7:0] sd,
                              input logic [2:0] rq, input logic [2:0] d0,
                              input logic [2:0] d1, input logic [2:0] d2,
                              input logic [2:0] eg, input logic [7:0] ed, input logic ee);
    vec_t v;
    v.r = r; v.se = se; v.sd = sd; v.rq = rq;
    v.d0 = d0; v.d1 = d1; v.d2 = d2;
    v.egnt = eg; v.edata = ed; v.eerr = ee;
    vecs.push_back(v);
  endfunction

  function automatic void rst_v();
    add(1'b1, 1'b0, 8'd0, 3'b000, 3'd0, 3'd0, 3'd0, 3'b000, 8'd0, 1'b0);
  endfunction

  function automatic void smp(input logic [7:0] d);
    add(1'b0, 1'b1, d, 3'b000, 3'd0, 3'd0, 3'd0, 3'b000, 8'd0, 1'b0);
  endfunction

  function automatic void idle();
    add(1'b0, 1'b0, 8'd0, 3'b000, 3'd0, 3'd0, 3'd0, 3'b000, 8'd0, 1'b0);
  endfunction

  // One clock cycle: drive, check gnt mid-cycle, check response after edge.
  task automatic apply(input vec_t v);
    rsp_t e;
    rst             = v.r;
    bus.sample_en   = v.se;
    bus.sample_data = v.sd;
    bus.req         = v.rq;
    bus.req_dist    = {v.d2, v.d1, v.d0};
    #3;
    check("gnt", 32'(bus.gnt), 32'(v.egnt));
    if (!v.r && v.egnt != 3'b000) begin
      e.id = oh_idx(v.egnt); e.data = v.edata; e.err = v.eerr;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    if (v.r) begin
      sb.delete();
      check("rst_valid", 32'(bus.rsp_valid), 32'd0);
      check("rst_data",  32'(bus.rsp_data),  32'd0);
      check("rst_err",   32'(bus.rsp_err),   32'd0);
      check("rst_id",    32'(bus.rsp_id),    32'd0);
    end else if (sb.size() > 0) begin
      e = sb.pop_front();
      check("rsp_valid", 32'(bus.rsp_valid), 32'd1);
      check("rsp_id",    32'(bus.rsp_id),    32'(e.id));
      check("rsp_data",  32'(bus.rsp_data),  32'(e.data));
      check("rsp_err",   32'(bus.rsp_err),   32'(e.err));
    end else begin
      check("idle_valid", 32'(bus.rsp_valid), 32'd0);
    end
  endtask

  initial begin
    vec_t v;
    rst = 1'b1;
    bus.sample_en = 1'b0; bus.sample_data = '0; bus.req = '0; bus.req_dist = '0;

    // Fill and lookup: 13,12,11,10 for k=1..4 on requester 0.
    rst_v(); rst_v();
    smp(8'd10); smp(8'd11); smp(8'd12); smp(8'd13);
    add(0, 0, 0, 3'b001, 3'd1, 0, 0, 3'b001, 8'd13, 0);
    add(0, 0, 0, 3'b001, 3'd2, 0, 0, 3'b001, 8'd12, 0);
    add(0, 0, 0, 3'b001, 3'd3, 0, 0, 3'b001, 8'd11, 0);
    add(0, 0, 0, 3'b001, 3'd4, 0, 0, 3'b001, 8'd10, 0);
    idle();

    // Wrap-around: 9 samples then k=1 -> 8; one more sample then k=4 -> 6.
    rst_v();
    for (int i = 0; i < 9; i++) smp(8'(i));
    add(0, 0, 0, 3'b001, 3'd1, 0, 0, 3'b001, 8'd8, 0);
    smp(8'd9);
    add(0, 0, 0, 3'b001, 3'd4, 0, 0, 3'b001, 8'd6, 0);

    // Errors with two samples (5,6): k=3, 0, 5 error; k=2 -> 5, k=1 -> 6.
    rst_v();
    smp(8'd5); smp(8'd6);
    add(0, 0, 0, 3'b001, 3'd3, 0, 0, 3'b001, 8'd0, 1);
    add(0, 0, 0, 3'b001, 3'd0, 0, 0, 3'b001, 8'd0, 1);
    add(0, 0, 0, 3'b001, 3'd5, 0, 0, 3'b001, 8'd0, 1);
    add(0, 0, 0, 3'b001, 3'd2, 0, 0, 3'b001, 8'd5, 0);
    add(0, 0, 0, 3'b001, 3'd1, 0, 0, 3'b001, 8'd6, 0);

    // Round-robin on history 20..23: order 0,1,2, then req2+req0 -> 0 then 2.
    rst_v();
    smp(8'd20); smp(8'd21); smp(8'd22); smp(8'd23);
    add(0, 0, 0, 3'b111, 3'd1, 3'd2, 3'd3, 3'b001, 8'd23, 0);
    add(0, 0, 0, 3'b110, 3'd1, 3'd2, 3'd3, 3'b010, 8'd22, 0);
    add(0, 0, 0, 3'b100, 3'd1, 3'd2, 3'd3, 3'b100, 8'd21, 0);
    idle();
    add(0, 0, 0, 3'b101, 3'd1, 3'd2, 3'd3, 3'b001, 8'd23, 0);
    add(0, 0, 0, 3'b100, 3'd1, 3'd2, 3'd3, 3'b100, 8'd21, 0);

    // Simultaneous write and read: k=1 with write 99 returns 4; then 99, 2.
    rst_v();
    smp(8'd1); smp(8'd2); smp(8'd3); smp(8'd4);
    add(0, 1, 8'd99, 3'b001, 3'd1, 0, 0, 3'b001, 8'd4, 0);
    add(0, 0, 0, 3'b001, 3'd1, 0, 0, 3'b001, 8'd99, 0);
    add(0, 0, 0, 3'b001, 3'd4, 0, 0, 3'b001, 8'd2, 0);
    // k=4 concurrent with a write of 99 returns the old oldest value 1.
    rst_v();
    smp(8'd1); smp(8'd2); smp(8'd3); smp(8'd4);
    add(0, 1, 8'd99, 3'b010, 0, 3'd4, 0, 3'b010, 8'd1, 0);

    // Reset mid-operation: req1 granted (k=2 -> 4), reset with requests held.
    add(0, 0, 0, 3'b010, 0, 3'd2, 0, 3'b010, 8'd4, 0);
    add(1, 0, 0, 3'b011, 3'd1, 3'd1, 0, 3'b000, 8'd0, 0);
    add(1, 0, 0, 3'b011, 3'd1, 3'd1, 0, 3'b000, 8'd0, 0);
    add(0, 0, 0, 3'b011, 3'd1, 3'd1, 0, 3'b001, 8'd0, 1);
    add(0, 0, 0, 3'b010, 3'd1, 3'd1, 0, 3'b010, 8'd0, 1);
    smp(8'd77);
    add(0, 0, 0, 3'b001, 3'd1, 0, 0, 3'b001, 8'd77, 0);

    @(posedge clk);
    #1;
    foreach (vecs[i]) apply(vecs[i]);

    // Hand sequence: all three held high back to back; rr_last is 0, so
    // grants rotate 1,2,0,... and every response is the single sample 77.
    for (int c = 0; c < 6; c++) begin
      v.r = 0; v.se = 0; v.sd = 0; v.rq = 3'b111;
      v.d0 = 3'd1; v.d1 = 3'd1; v.d2 = 3'd1;
      v.egnt = 3'(1 << ((c + 1) % 3)); v.edata = 8'd77; v.eerr = 0;
      apply(v);
    end
    // Hand sequence: sample_en=0 cycles do not advance history; k=2 stays
    // an error with one sample, then becomes valid after one more sample.
    v.rq = 3'b001; v.d0 = 3'd2; v.egnt = 3'b001; v.edata = 8'd0; v.eerr = 1;
    apply(v);
    v.rq = 3'b000; v.egnt = 3'b000;
    apply(v);
    v.se = 1; v.sd = 8'd88;
    apply(v);
    v.se = 0; v.rq = 3'b001; v.egnt = 3'b001; v.edata = 8'd77; v.eerr = 0;
    apply(v);
    v.rq = 3'b000; v.egnt = 3'b000;
    apply(v);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/past_history_arbiter.md
Name: past_history_arbiter

Overview:
- Shared history buffer for a sampled expression.
- Records the last DEPTH samples of `sample_data` into a ring, one slot per enabled clock edge.
- Multiple requesters ask for "value k samples ago" ($past-style lookups).
- Requesters are served one per cycle by a round-robin arbiter; data returns on a registered response port.

Parameters:
- WIDTH, 8, bit width of the sampled expression.
- DEPTH, 4, history slots; the maximum past distance; must be a power of two, at least 2.
- NREQ, 3, number of requesters; at least 1.
- DW, $clog2(DEPTH+1), width of one distance field. Derived, not overridable.

Ports:
- clk  in  1  sole clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- sample_en  in  1  capture `sample_data` this edge.
- sample_data  in  WIDTH  expression value to record.
- req  in  NREQ  per-requester request; held high until granted.
- req_dist  in  NREQ*DW  per-requester distance k; slice i is [i*DW +: DW]; must be stable while req[i] is high.
- gnt  out  NREQ  one-hot grant, combinational from req and arbiter pointer.
- rsp_valid  out  1  response valid; registered.
- rsp_id  out  $clog2(NREQ) (min 1)  index of the served requester.
- rsp_data  out  WIDTH  past value.
- rsp_err  out  1  distance invalid (k=0 or k exceeds stored history).

Behaviour:
- State:
  - ring mem[DEPTH] of WIDTH bits;
  - wr_ptr, log2(DEPTH) bits;
  - fill_cnt, 0..DEPTH, saturating;
  - rr_last, the last granted index.
- Reset, held any number of cycles:
  - wr_ptr=0, fill_cnt=0, rr_last=NREQ-1 (requester 0 has top priority first);
  - rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0.
  - mem contents are don't-care; fill_cnt=0 makes them unreadable.
  - gnt=0 while rst=1.
  - Reset mid-traffic discards the pending response and the whole history.
- Sampling, on an edge with sample_en=1:
  - mem[wr_ptr] <= sample_data;
  - wr_ptr <= wr_ptr+1, wrapping DEPTH-1 -> 0;
  - fill_cnt <= min(fill_cnt+1, DEPTH).
- Arbitration, combinational:
  - Search starts at rr_last+1 and wraps modulo NREQ.
  - The first set req bit gets its gnt bit; at most one gnt bit is high.
  - No req means gnt=0 and rr_last is unchanged.
  - On a grant edge, rr_last <= granted index.
  - A requester drops req on the edge after it sees gnt.
  - A persistently requesting master waits at most NREQ-1 cycles.
- Lookup:
  - Uses pre-edge state (preponed-sample semantics).
  - With k = the granted req_dist: read index = (wr_ptr - k) mod DEPTH, using current wr_ptr.
  - k=1 is the most recently written sample.
  - A write and a read in the same cycle: the read never sees the value being written that edge.
  - k=DEPTH reads the oldest slot, which is the slot being overwritten that edge. The old value is returned.
- Error rule:
  - k==0 or k>fill_cnt sets rsp_err=1 and rsp_data=0.
  - Otherwise rsp_err=0.
  - k>DEPTH is always an error.
- Response, latency 1:
  - Edge after a grant: rsp_valid=1, rsp_id=granted index, rsp_data and rsp_err per the lookup.
  - Cycles with no grant: rsp_valid=0; rsp_data and rsp_err hold their previous values.
  - There is no backpressure on the response. The consumer must accept every cycle.
- Throughput: one grant per cycle, back to back; a new grant may coincide with rsp_valid of the previous one.
- sample_en=0 cycles do not advance the history. Distance counts samples, not clock cycles.

Test Plan:
- Fill and lookup:
  - Stimulus: rst 2 cycles; sample 10,11,12,13 (sample_en=1 four edges); then req0 with k=1..4 on successive cycles.
  - Required: rsp_data = 13,12,11,10; rsp_err=0; rsp_id=0; each rsp_valid exactly 1 cycle after the matching gnt.
- Wrap-around:
  - Stimulus: sample 0..9 continuously; then req k=4.
  - Required: rsp_data=6. After 9 samples, k=1 gives 8.
- Errors:
  - Stimulus: after reset plus 2 samples (5,6), request k=3, k=0 and k=5.
  - Required: each has rsp_err=1, rsp_data=0; k=2 gives 5 with err=0.
- Round-robin:
  - Stimulus: after reset, all three req held high with k=1,2,3 on history 20,21,22,23.
  - Required: grants in order 0,1,2; responses 23,22,21.
  - Stimulus: then only req2 and req0 re-asserted.
  - Required: grant order 0, then 2.
- Simultaneous write and read:
  - Stimulus: history 1,2,3,4 (full); same edge sample_en=1 with data 99 and granted k=1; then k=4.
  - Required: first response 4. Next-cycle k=1 gives 99 and k=4 gives 2.
  - Stimulus: k=4 concurrent with a write of 99.
  - Required: returns 1.
- Reset mid-operation:
  - Stimulus: full history with req1 granted; assert rst on the following edge.
  - Required: rsp_valid=0 and gnt=0 during reset. After release, k=1 gives rsp_err=1 until a new sample is taken. The first grant afterwards goes to requester 0.
